uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_baud_gen.sv | 33 +++
 rtl/uart_tx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and bit-timing constant functions,
// used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int bit_cycles(input int sys_clk_hz, input int baud);
    return sys_clk_hz / baud;
  endfunction

  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter for the transmitter: emits a one-cycle bit_tick at the end
// of every BIT_CYCLES-long bit; clr restarts the period from zero.
module uart_tx_baud_gen
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = 2604,
  parameter int CNT_W      = cnt_width(BIT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last   = (r_cnt == LAST);
  assign bit_tick = w_last && !clr && !rst;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word intake, 8N1-style framing (5..8 data bits,
// one stop bit), LSB first, with a flop-driven serial line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int system_clock = 25000000,
  parameter int tx_baudrate  = 9600,
  parameter int data_bits    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [data_bits-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy
);

  localparam int         BIT_CYCLES = bit_cycles(system_clock, tx_baudrate);
  localparam int         CNT_W      = cnt_width(BIT_CYCLES);
  localparam logic [2:0] LAST_IDX   = 3'(data_bits - 1);

  generate
    if (BIT_CYCLES < 2) begin : g_bad_bit_cycles
      $error("uart_tx: system_clock/tx_baudrate must be at least 2");
    end
    if (data_bits < 5 || data_bits > 8) begin : g_bad_data_bits
      $error("uart_tx: data_bits must be in 5..8");
    end
  endgenerate

  uart_state_t          r_state, w_state_nxt;
  logic [data_bits-1:0] r_shift, w_shift_nxt;
  logic [2:0]           r_idx, w_idx_nxt;
  logic                 r_serial, w_serial_nxt;
  logic                 w_accept;
  logic                 w_tick;
  logic                 w_clr;

  assign tx_ready  = (r_state == IDLE) && !rst;
  assign tx_busy   = (r_state != IDLE);
  assign tx_serial = r_serial;
  assign w_accept  = tx_valid && tx_ready;
  // Holding the counter clear through IDLE gives every start bit a full period.
  assign w_clr     = (r_state == IDLE);

  uart_tx_baud_gen #(
    .BIT_CYCLES (BIT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .bit_tick (w_tick)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_idx_nxt    = r_idx;
    w_serial_nxt = r_serial;
    case (r_state)
      IDLE: begin
        w_serial_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt  = START;
          w_shift_nxt  = tx_data;
          w_idx_nxt    = '0;
          w_serial_nxt = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt  = DATA;
          w_serial_nxt = r_shift[0];
          w_shift_nxt  = r_shift >> 1;
          w_idx_nxt    = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt  = STOP;
            w_serial_nxt = 1'b1;
          end else begin
            w_idx_nxt    = r_idx + 3'd1;
            w_serial_nxt = r_shift[0];
            w_shift_nxt  = r_shift >> 1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_nxt  = IDLE;
          w_serial_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_serial_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_serial <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_serial <= w_serial_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

endmodule
